// File: rtl/reset_sequencer.sv
// Sequenced reset controller: releases NUM_STAGES domains in ascending order after board reset sync.
// Latency: first domain released STAGE_DELAY cycles after sync, then STAGE_DELAY+1 per acknowledged stage.
// Backpressure: sequencing stalls in WAIT_ACK until stage_ack[idx]; RESET_SEQ_ACK_TIMEOUT_EN adds a timeout.
module reset_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int STAGE_DELAY = 16,
   parameter int SYNC_DEPTH  = 2,
   parameter int HOLD_CYCLES = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  async_reset,
   input  logic                  sw_reset_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] o_reset,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   localparam int CNT_MAX = (STAGE_DELAY > HOLD_CYCLES) ? STAGE_DELAY : HOLD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   generate
      if (NUM_STAGES < 1 || NUM_STAGES > 8 || STAGE_DELAY < 1 || SYNC_DEPTH < 2 ||
          HOLD_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
         $error("reset_sequencer: parameter out of range");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_WAIT_SYNC = 3'd0,
      S_RELEASE   = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_DONE      = 3'd3,
      S_HOLD      = 3'd4,
      S_ERROR     = 3'd5
   } state_t;

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  rst_sync_q;
   logic                  rst_sync_d;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_STAGES-1:0] rst_q, rst_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

`ifdef RESET_SEQ_ACK_TIMEOUT_EN
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  err_q, err_d;
`endif

   // rst_sync is the chain tail; rst_sync_d is the value it takes at the next edge,
   // so the FSM leaves WAIT_SYNC on the same edge that rst_sync falls.
   assign rst_sync_q = sync_q[SYNC_DEPTH-1];
   assign rst_sync_d = sync_q[SYNC_DEPTH-2];

   // Reset synchronizer: asserts asynchronously, shifts in zeros after release.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) sync_q <= '1;
      else             sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b0};
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state_q <= S_WAIT_SYNC;
         idx_q   <= '0;
         cnt_q   <= '0;
         rst_q   <= '1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
         tmo_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rst_q   <= rst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
         tmo_q   <= tmo_d;
         err_q   <= err_d;
`endif
      end
   end

   // Next-state logic; outputs are computed here and registered, never taken from inputs directly.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      busy_d  = busy_q;
      done_d  = done_q;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
      tmo_d   = tmo_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_WAIT_SYNC: begin
            if (!rst_sync_d || !rst_sync_q) begin
               state_d = S_RELEASE;
               idx_d   = '0;
               cnt_d   = CNT_W'(STAGE_DELAY - 1);
            end
         end
         S_RELEASE: begin
            if (cnt_q == '0) begin
               rst_d[idx_q] = 1'b0;
               state_d      = S_WAIT_ACK;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
               tmo_d        = '0;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT_ACK: begin
            if (stage_ack[idx_q]) begin
               if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RELEASE;
                  idx_d   = idx_q + 1'b1;
                  cnt_d   = CNT_W'(STAGE_DELAY - 1);
               end
            end
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
            else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
               state_d = S_ERROR;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         // ERROR is only reachable with the timeout enabled; both re-reset the same way.
         S_DONE, S_ERROR: begin
            if (sw_reset_req) begin
               state_d = S_HOLD;
               idx_d   = '0;
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
               rst_d   = '1;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_RELEASE;
               idx_d   = '0;
               cnt_d   = CNT_W'(STAGE_DELAY - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_WAIT_SYNC;
      endcase
   end

   assign o_reset = rst_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
`ifdef RESET_SEQ_ACK_TIMEOUT_EN
   assign o_error = err_q;
`else
   assign o_error = 1'b0;
`endif

endmodule
